// File: rtl/game_countdown_pkg.sv
// Shared definitions for the whack-a-mole round timer: state encodings,
// BCD digit width, the game-wide 1 Hz divider constant and a BCD helper.
package game_countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int BCD_W = 4;

   // clock_divider terminal count for a 1 Hz tick from clk_sys = 50 MHz
   localparam logic [27:0] DIV_1HZ_50MHZ = 28'd49_999_999;

   function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned v);
      return {4'(v / 32'd10), 4'(v % 32'd10)};
   endfunction

endpackage

// File: rtl/game_countdown_if.sv
// Signal bundle between the round timer, its clock_divider and the display.
// The timer is the slave side; the surrounding game logic is the master.
interface game_countdown_if #(
   parameter int CNT_W = 28
);
   import game_countdown_pkg::*;

   logic [CNT_W-1:0] divider_count;
   logic             start;
   logic             pause;
   logic             divider_enable;
   logic [BCD_W-1:0] seconds_tens;
   logic [BCD_W-1:0] seconds_ones;
   logic             running;
   logic             time_up;

   modport master (
      output divider_count, start, pause,
      input  divider_enable, seconds_tens, seconds_ones, running, time_up
   );

   modport slave (
      input  divider_count, start, pause,
      output divider_enable, seconds_tens, seconds_ones, running, time_up
   );

endinterface

// File: rtl/game_countdown_bcd_digit_down.sv
// One BCD digit of a down-counter (bcd_digit_down): decrements on borrow_in,
// wrapping 0 -> 9 and passing the borrow to the next digit.
module game_countdown_bcd_digit_down
   import game_countdown_pkg::*;
(
   input  logic [BCD_W-1:0] digit_in,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] digit_out,
   output logic             borrow_out
);

   always_comb begin
      digit_out  = digit_in;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit_in == '0) begin
            digit_out  = 4'd9;
            borrow_out = 1'b1;
         end else begin
            digit_out = digit_in - 4'd1;
         end
      end
   end

endmodule

// File: rtl/game_countdown.sv
// Round timer: counts a two-digit BCD seconds value down on each divider
// terminal count and pulses time_up once when the round expires.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | waiting for start, seconds preloaded, divider frozen
//  ST_RUNNING | divider enabled, each divider_count==0 removes one second
//  ST_PAUSED  | divider frozen, seconds held until pause drops
//  ST_DONE    | seconds at 00, waiting for start
module game_countdown
   import game_countdown_pkg::*;
#(
   parameter int START_SECONDS = 60,
   parameter int CNT_W         = 28
) (
   input logic             clk,
   input logic             reset,
   game_countdown_if.slave bus
);

   localparam logic [2*BCD_W-1:0] START_BCD = to_bcd(START_SECONDS);

   state_t           state;
   logic [BCD_W-1:0] tens;
   logic [BCD_W-1:0] ones;
   logic             time_up_q;

   logic             tick;
   logic             at_one;
   logic [BCD_W-1:0] ones_dec;
   logic [BCD_W-1:0] tens_dec;
   logic             ones_borrow;
   logic             tens_borrow;

   assign tick   = (bus.divider_count == {CNT_W{1'b0}}) && (state == ST_RUNNING);
   assign at_one = (tens == 4'd0) && (ones == 4'd1);

   game_countdown_bcd_digit_down u_ones (
      .digit_in   (ones),
      .borrow_in  (1'b1),
      .digit_out  (ones_dec),
      .borrow_out (ones_borrow)
   );

   game_countdown_bcd_digit_down u_tens (
      .digit_in   (tens),
      .borrow_in  (ones_borrow),
      .digit_out  (tens_dec),
      .borrow_out (tens_borrow)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         tens      <= START_BCD[2*BCD_W-1:BCD_W];
         ones      <= START_BCD[BCD_W-1:0];
         time_up_q <= 1'b0;
      end else begin
         time_up_q <= 1'b0;
         if (bus.start) begin
            state <= ST_RUNNING;
            tens  <= START_BCD[2*BCD_W-1:BCD_W];
            ones  <= START_BCD[BCD_W-1:0];
         end else begin
            case (state)
               ST_RUNNING: begin
                  if (tick && at_one) begin
                     tens      <= 4'd0;
                     ones      <= 4'd0;
                     time_up_q <= 1'b1;
                     state     <= ST_DONE;
                  // a tens borrow would mean 00 -> 99; refuse it outright
                  end else if (tick && !tens_borrow) begin
                     tens <= tens_dec;
                     ones <= ones_dec;
                     if (bus.pause) state <= ST_PAUSED;
                  end else if (bus.pause) begin
                     state <= ST_PAUSED;
                  end
               end
               ST_PAUSED: begin
                  if (!bus.pause) state <= ST_RUNNING;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.divider_enable = (state == ST_RUNNING);
   assign bus.running        = (state == ST_RUNNING);
   assign bus.seconds_tens   = tens;
   assign bus.seconds_ones   = ones;
   assign bus.time_up        = time_up_q;

endmodule

// File: tb/tb_game_countdown.sv
// Bench for game_countdown: two instances (3 s and 12 s rounds) each fed by a
// clock_divider model with counter_max=4, checked through an event scoreboard.
module tb_game_countdown;
   import game_countdown_pkg::*;

   localparam logic [27:0] CNT_MAX = 28'd4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   game_countdown_if #(.CNT_W(28)) bus_a ();
   game_countdown_if #(.CNT_W(28)) bus_b ();

   game_countdown #(.START_SECONDS(3), .CNT_W(28)) dut_a (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus_a.slave)
   );

   game_countdown #(.START_SECONDS(12), .CNT_W(28)) dut_b (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus_b.slave)
   );

   // clock_divider models: count down, reload after 0, hold while disabled
   logic [27:0] div_a, div_b;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_a <= CNT_MAX;
      else if (bus_a.divider_enable) div_a <= (div_a == 28'd0) ? CNT_MAX : div_a - 28'd1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_b <= CNT_MAX;
      else if (bus_b.divider_enable) div_b <= (div_b == 28'd0) ? CNT_MAX : div_b - 28'd1;
   end
   assign bus_a.divider_count = div_a;
   assign bus_b.divider_count = div_b;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   bit mon_on = 1'b0;

   typedef struct {
      logic [10:0] obs;
      int          cyc;
   } ev_t;

   ev_t q_a[$];
   ev_t q_b[$];
   ev_t e_a, e_b;

   logic [10:0] obs_a, obs_b, prev_a, prev_b;
   assign obs_a = {bus_a.divider_enable, bus_a.running, bus_a.seconds_tens, bus_a.seconds_ones, bus_a.time_up};
   assign obs_b = {bus_b.divider_enable, bus_b.running, bus_b.seconds_tens, bus_b.seconds_ones, bus_b.time_up};

   function automatic logic [10:0] mk(input bit run, input int secs, input bit tu);
      return {run, run, 4'(secs / 10), 4'(secs % 10), tu};
   endfunction

   task automatic push_a(input bit run, input int secs, input bit tu, input int c);
      q_a.push_back('{mk(run, secs, tu), c});
   endtask

   task automatic push_b(input bit run, input int secs, input bit tu, input int c);
      q_b.push_back('{mk(run, secs, tu), c});
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h required=%0h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   // monitors: any change of the observed outputs must match the next queued event
   always @(negedge clk) begin
      if (mon_on && obs_a !== prev_a) begin
         tests++;
         if (q_a.size() == 0) begin
            fails++;
            $display("FAIL mon_a unexpected event cyc=%0d got=%h required=none", cyc, obs_a);
         end else begin
            e_a = q_a.pop_front();
            if (e_a.obs !== obs_a || e_a.cyc != cyc) begin
               fails++;
               $display("FAIL mon_a got=%h@%0d required=%h@%0d", obs_a, cyc, e_a.obs, e_a.cyc);
            end
         end
      end
      prev_a = obs_a;
   end

   always @(negedge clk) begin
      if (mon_on && obs_b !== prev_b) begin
         tests++;
         if (q_b.size() == 0) begin
            fails++;
            $display("FAIL mon_b unexpected event cyc=%0d got=%h required=none", cyc, obs_b);
         end else begin
            e_b = q_b.pop_front();
            if (e_b.obs !== obs_b || e_b.cyc != cyc) begin
               fails++;
               $display("FAIL mon_b got=%h@%0d required=%h@%0d", obs_b, cyc, e_b.obs, e_b.cyc);
            end
         end
      end
      prev_b = obs_b;
   end

   // call at a negedge; returns at the negedge whose following posedge is edge e
   task automatic wait_to(input int e);
      while (cyc < e - 1) @(negedge clk);
   endtask

   task automatic check_a(input string tag, input int secs, input bit run, input bit tu);
      check({tag, "_a_tens"}, 32'(bus_a.seconds_tens), 32'(secs / 10));
      check({tag, "_a_ones"}, 32'(bus_a.seconds_ones), 32'(secs % 10));
      check({tag, "_a_running"}, 32'(bus_a.running), 32'(run));
      check({tag, "_a_enable"}, 32'(bus_a.divider_enable), 32'(run));
      check({tag, "_a_time_up"}, 32'(bus_a.time_up), 32'(tu));
   endtask

   int c0;

   initial begin
      rst_n = 1'b0;
      bus_a.start = 1'b0; bus_a.pause = 1'b0;
      bus_b.start = 1'b0; bus_b.pause = 1'b0;

      // 1: reset state and idle hold
      repeat (3) @(negedge clk);
      check_a("rst", 3, 1'b0, 1'b0);
      check("rst_b_tens", 32'(bus_b.seconds_tens), 32'd1);
      check("rst_b_ones", 32'(bus_b.seconds_ones), 32'd2);
      rst_n = 1'b1;
      mon_on = 1'b1;
      repeat (20) @(negedge clk);
      check_a("idle", 3, 1'b0, 1'b0);
      check("idle_div_a", 32'(div_a), 32'd4);

      // 2 + 3: full 3 s round on A, 12 s round (tens borrow) on B
      c0 = cyc + 1;
      push_a(1'b1, 3, 1'b0, c0);
      push_a(1'b1, 2, 1'b0, c0 + 5);
      push_a(1'b1, 1, 1'b0, c0 + 10);
      push_a(1'b0, 0, 1'b1, c0 + 15);
      push_a(1'b0, 0, 1'b0, c0 + 16);
      for (int s = 12; s >= 1; s--) push_b(1'b1, s, 1'b0, c0 + 5 * (12 - s));
      push_b(1'b0, 0, 1'b1, c0 + 60);
      push_b(1'b0, 0, 1'b0, c0 + 61);
      bus_a.start = 1'b1; bus_b.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      wait_to(c0 + 16);
      check("borrow_b_tens", 32'(bus_b.seconds_tens), 32'd0);
      check("borrow_b_ones", 32'(bus_b.seconds_ones), 32'd9);
      wait_to(c0 + 82);
      check_a("done_hold", 0, 1'b0, 1'b0);
      check("done_b_ones", 32'(bus_b.seconds_ones), 32'd0);
      check("done_b_tens", 32'(bus_b.seconds_tens), 32'd0);

      // 4: pause on a tick edge, long pause, then a pause between ticks
      c0 = cyc + 1;
      push_a(1'b1, 3, 1'b0, c0);
      push_a(1'b0, 2, 1'b0, c0 + 5);
      push_a(1'b1, 2, 1'b0, c0 + 22);
      push_a(1'b1, 1, 1'b0, c0 + 27);
      push_a(1'b0, 1, 1'b0, c0 + 29);
      push_a(1'b1, 1, 1'b0, c0 + 32);
      push_a(1'b0, 0, 1'b1, c0 + 35);
      push_a(1'b0, 0, 1'b0, c0 + 36);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      wait_to(c0 + 5);
      bus_a.pause = 1'b1;
      wait_to(c0 + 15);
      check_a("paused", 2, 1'b0, 1'b0);
      check("paused_div_a", 32'(div_a), 32'd4);
      wait_to(c0 + 22);
      bus_a.pause = 1'b0;
      wait_to(c0 + 29);
      bus_a.pause = 1'b1;
      wait_to(c0 + 31);
      check("paused2_div_a", 32'(div_a), 32'd2);
      wait_to(c0 + 32);
      bus_a.pause = 1'b0;
      wait_to(c0 + 40);

      // 5: restart on the edge that would expire the round
      c0 = cyc + 1;
      push_a(1'b1, 3, 1'b0, c0);
      push_a(1'b1, 2, 1'b0, c0 + 5);
      push_a(1'b1, 1, 1'b0, c0 + 10);
      push_a(1'b1, 3, 1'b0, c0 + 15);
      push_a(1'b1, 2, 1'b0, c0 + 20);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      wait_to(c0 + 15);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;

      // 6: asynchronous reset between edges while running at 2
      wait_to(c0 + 23);
      push_a(1'b0, 3, 1'b0, c0 + 23);
      push_b(1'b0, 12, 1'b0, c0 + 23);
      #2 rst_n = 1'b0;
      #1;
      check_a("async_rst", 3, 1'b0, 1'b0);
      check("async_rst_div_a", 32'(div_a), 32'd4);
      check("async_rst_b_tens", 32'(bus_b.seconds_tens), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_a("post_rst", 3, 1'b0, 1'b0);

      check("q_a_drained", 32'(q_a.size()), 32'd0);
      check("q_b_drained", 32'(q_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
